// File: rtl/fp9_pkg.sv
// rtl/fp9_pkg.sv - shared widths, state encoding and field helpers for the fp9 add/sub responder
package fp9_pkg;

    localparam int EXP_W    = 3;
    localparam int FRAC_W   = 5;
    localparam int MANT_W   = 6;
    localparam int EXP_BIAS = 3;
    localparam int EXP_MAX  = 7;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } fp9_state_t;

    function automatic logic fp9_sign(input logic [8:0] v);
        return v[8];
    endfunction

    function automatic logic [EXP_W-1:0] fp9_exp(input logic [8:0] v);
        return v[7:5];
    endfunction

    // Hidden bit is implied only for a nonzero exponent; exponent 0 encodes zero.
    function automatic logic [MANT_W-1:0] fp9_mant(input logic [8:0] v);
        return (v[7:5] != 3'd0) ? {1'b1, v[4:0]} : '0;
    endfunction

    function automatic logic [8:0] fp9_pack_fields(input logic       sgn,
                                                   input logic [2:0] e,
                                                   input logic [4:0] f);
        return {sgn, e, f};
    endfunction

endpackage

// File: rtl/fp9_pack.sv
// rtl/fp9_pack.sv - final result assembly with overflow saturation and underflow flush
module fp9_pack
    import fp9_pkg::*;
(
    input  logic              sign,
    input  logic signed [4:0] exp_in,
    input  logic [4:0]        frac,
    input  logic              is_zero,
    output logic [8:0]        s,
    output logic              zero,
    output logic              ovf
);

    localparam logic signed [4:0] EXP_HI = 5'(EXP_MAX);
    localparam logic signed [4:0] EXP_LO = 5'sd1;

    // Zero magnitude and underflow flush to +0; overflow saturates to the largest finite value.
    always_comb begin
        s    = '0;
        zero = 1'b0;
        ovf  = 1'b0;
        if (is_zero || (exp_in < EXP_LO)) begin
            zero = 1'b1;
        end else if (exp_in > EXP_HI) begin
            s   = {sign, 3'b111, 5'b11111};
            ovf = 1'b1;
        end else begin
            s = fp9_pack_fields(sign, exp_in[2:0], frac);
        end
    end

endmodule

// File: rtl/fp9_addsub_seq.sv
// rtl/fp9_addsub_seq.sv - handshaked sequential 9-bit float add/subtract (align/add/normalize FSM)
module fp9_addsub_seq
    import fp9_pkg::*;
#(
    parameter int GUARD_BITS = 3,
    parameter int MAX_ALIGN  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic       addsub,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [8:0] s,
    output logic       zero,
    output logic       ovf,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int          MW        = MANT_W + GUARD_BITS;
    localparam logic [3:0]  ALIGN_CAP = 4'(MAX_ALIGN);

    fp9_state_t        state, state_n;
    logic              first, first_n;
    logic [8:0]        a_r, a_n, b_r, b_n;
    logic              op_r, op_n;
    logic              sign_big, sign_big_n, sign_small, sign_small_n;
    logic signed [4:0] exp_r, exp_n;
    logic [MW-1:0]     m_big, m_big_n, m_small, m_small_n;
    logic [MW:0]       sum_r, sum_n;
    logic              res_sign, res_sign_n;
    logic [3:0]        cnt, cnt_n;

    logic [2:0]        ea, eb;
    logic [MW-1:0]     ma_ext, mb_ext;
    logic              sb_eff;
    logic [3:0]        diff;

    logic [8:0]        pk_s;
    logic              pk_zero, pk_ovf;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Next-state and datapath: first ALIGN cycle unpacks/swaps, later ones shift; NORM mirrors that.
    always_comb begin
        state_n      = state;
        first_n      = first;
        a_n          = a_r;
        b_n          = b_r;
        op_n         = op_r;
        sign_big_n   = sign_big;
        sign_small_n = sign_small;
        exp_n        = exp_r;
        m_big_n      = m_big;
        m_small_n    = m_small;
        sum_n        = sum_r;
        res_sign_n   = res_sign;
        cnt_n        = cnt;
        ea           = fp9_exp(a_r);
        eb           = fp9_exp(b_r);
        ma_ext       = {fp9_mant(a_r), {GUARD_BITS{1'b0}}};
        mb_ext       = {fp9_mant(b_r), {GUARD_BITS{1'b0}}};
        sb_eff       = fp9_sign(b_r) ^ op_r;
        diff         = '0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_n     = a;
                    b_n     = b;
                    op_n    = addsub;
                    first_n = 1'b1;
                    state_n = ALIGN;
                end
            end
            ALIGN: begin
                if (first) begin
                    first_n = 1'b0;
                    if (ea == 3'd0) begin
                        // A is zero: B (possibly also zero) carries the exponent, A adds nothing.
                        sign_big_n   = sb_eff;
                        exp_n        = $signed({2'b00, eb});
                        m_big_n      = mb_ext;
                        sign_small_n = fp9_sign(a_r);
                        m_small_n    = '0;
                    end else if (eb == 3'd0) begin
                        sign_big_n   = fp9_sign(a_r);
                        exp_n        = $signed({2'b00, ea});
                        m_big_n      = ma_ext;
                        sign_small_n = sb_eff;
                        m_small_n    = '0;
                    end else if (ea >= eb) begin
                        sign_big_n   = fp9_sign(a_r);
                        exp_n        = $signed({2'b00, ea});
                        m_big_n      = ma_ext;
                        sign_small_n = sb_eff;
                        m_small_n    = mb_ext;
                        diff         = {1'b0, ea - eb};
                    end else begin
                        sign_big_n   = sb_eff;
                        exp_n        = $signed({2'b00, eb});
                        m_big_n      = mb_ext;
                        sign_small_n = fp9_sign(a_r);
                        m_small_n    = ma_ext;
                        diff         = {1'b0, eb - ea};
                    end
                    if (diff > ALIGN_CAP) begin
                        diff = ALIGN_CAP;
                    end
                    cnt_n = diff;
                    if (diff == 4'd0) begin
                        state_n = ADD;
                    end
                end else begin
                    // Shift right by one, folding the lost bit into the sticky LSB.
                    m_small_n = {1'b0, m_small[MW-1:1]} | {{(MW-1){1'b0}}, m_small[0]};
                    cnt_n     = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_n = ADD;
                    end
                end
            end
            ADD: begin
                if (sign_big == sign_small) begin
                    sum_n      = {1'b0, m_big} + {1'b0, m_small};
                    res_sign_n = sign_big;
                end else if (m_big >= m_small) begin
                    sum_n      = {1'b0, m_big} - {1'b0, m_small};
                    res_sign_n = sign_big;
                end else begin
                    sum_n      = {1'b0, m_small} - {1'b0, m_big};
                    res_sign_n = sign_small;
                end
                first_n = 1'b1;
                state_n = NORM;
            end
            NORM: begin
                if (first) begin
                    first_n = 1'b0;
                    if (sum_r[MW]) begin
                        sum_n   = {1'b0, sum_r[MW:1]};
                        exp_n   = exp_r + 5'sd1;
                        state_n = DONE;
                    end else if ((sum_r == '0) || sum_r[MW-1]) begin
                        state_n = DONE;
                    end
                end else begin
                    sum_n = {sum_r[MW-1:0], 1'b0};
                    exp_n = exp_r - 5'sd1;
                    if (sum_r[MW-2]) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pack sees the values being written on the NORM->DONE edge so results register with DONE.
    fp9_pack u_pack (
        .sign    (res_sign_n),
        .exp_in  (exp_n),
        .frac    (sum_n[MW-2 -: FRAC_W]),
        .is_zero (sum_n == '0),
        .s       (pk_s),
        .zero    (pk_zero),
        .ovf     (pk_ovf)
    );

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            first      <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            op_r       <= 1'b0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_r      <= '0;
            m_big      <= '0;
            m_small    <= '0;
            sum_r      <= '0;
            res_sign   <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            first      <= first_n;
            a_r        <= a_n;
            b_r        <= b_n;
            op_r       <= op_n;
            sign_big   <= sign_big_n;
            sign_small <= sign_small_n;
            exp_r      <= exp_n;
            m_big      <= m_big_n;
            m_small    <= m_small_n;
            sum_r      <= sum_n;
            res_sign   <= res_sign_n;
            cnt        <= cnt_n;
        end
    end

    // Result registers load once per operation and hold through DONE and afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            zero <= 1'b0;
            ovf  <= 1'b0;
        end else if ((state == NORM) && (state_n == DONE)) begin
            s    <= pk_s;
            zero <= pk_zero;
            ovf  <= pk_ovf;
        end
    end

endmodule

// File: tb/tb_fp9_addsub_seq.sv
// tb/tb_fp9_addsub_seq.sv - self-checking bench for fp9_addsub_seq
module tb_fp9_addsub_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] a = '0;
    logic [8:0] b = '0;
    logic       addsub = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] s;
    logic       zero;
    logic       ovf;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    fp9_addsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .addsub    (addsub),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .zero      (zero),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: values as integer mantissas scaled by 8 guard steps, plain arithmetic.
    task automatic model(input logic [8:0] x, input logic [8:0] y, input logic op,
                         output logic [8:0] rs, output logic rz, output logic ro, output int lat);
        int ex, ey, sx, sy, mx, my, e, d, mb, ms, sb, ss, m, sg, l;
        ex = int'(x[7:5]);
        ey = int'(y[7:5]);
        sx = int'(x[8]);
        sy = int'(y[8] ^ op);
        mx = (ex == 0) ? 0 : (32 + int'(x[4:0])) * 8;
        my = (ey == 0) ? 0 : (32 + int'(y[4:0])) * 8;
        d  = 0;
        if (ex == 0) begin
            e = ey; mb = my; sb = sy; ms = 0; ss = sx;
        end else if (ey == 0) begin
            e = ex; mb = mx; sb = sx; ms = 0; ss = sy;
        end else if (ex >= ey) begin
            e = ex; mb = mx; sb = sx; ms = my; ss = sy; d = ex - ey;
        end else begin
            e = ey; mb = my; sb = sy; ms = mx; ss = sx; d = ey - ex;
        end
        if (d > 7) d = 7;
        for (int i = 0; i < d; i++) ms = (ms / 2) | (ms % 2);
        if (sb == ss) begin
            m = mb + ms; sg = sb;
        end else if (mb >= ms) begin
            m = mb - ms; sg = sb;
        end else begin
            m = ms - mb; sg = ss;
        end
        l  = 0;
        rs = '0;
        rz = 1'b0;
        ro = 1'b0;
        if (m == 0) begin
            rz = 1'b1;
        end else begin
            if (m >= 512) begin
                m = m / 2;
                e = e + 1;
            end
            while (m < 256) begin
                m = m * 2;
                e = e - 1;
                l = l + 1;
            end
            if (e > 7) begin
                rs = {sg[0], 8'hFF};
                ro = 1'b1;
            end else if (e < 1) begin
                rz = 1'b1;
            end else begin
                rs = {sg[0], 3'(e), 5'((m / 8) % 32)};
            end
        end
        lat = 4 + d + l;
    endtask

    task automatic do_op(input logic [8:0] xa, input logic [8:0] xb, input logic xop,
                         input logic [8:0] es, input logic ez, input logic eo, input int lat,
                         input int hold, input bit ghost);
        int n;
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        a = xa; b = xb; addsub = xop; in_valid = 1'b1;
        @(posedge clk); #1;
        check("ready_busy", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        a = 9'($urandom); b = 9'($urandom); addsub = 1'($urandom);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
        check("latency", n, lat - 1);
        check("s", s, es);
        check("zero", zero, ez);
        check("ovf", ovf, eo);
        repeat (hold) begin
            @(negedge clk);
            if (ghost) begin
                in_valid = 1'b1; a = 9'($urandom); b = 9'($urandom);
            end
            @(posedge clk); #1;
            check("hold_s", s, es);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_after", in_ready, 1);
        check("valid_after", out_valid, 0);
        check("s_after", s, es);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [8:0] rs;
        logic       rz, ro;
        logic [8:0] ra, rb;
        logic       rop;
        int         lat;
        int         seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_zero", zero, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(9'b001010000, 9'b001000000, 1'b0, 9'b001101000, 1'b0, 1'b0, 4, 1, 1'b0);
        do_op(9'b000010000, 9'b000010000, 1'b1, 9'b000000000, 1'b1, 1'b0, 4, 0, 1'b0);
        do_op(9'b001110000, 9'b001111000, 1'b1, 9'b100100000, 1'b0, 1'b0, 6, 2, 1'b0);
        do_op(9'b010111100, 9'b001111000, 1'b1, 9'b010101110, 1'b0, 1'b0, 6, 0, 1'b0);
        do_op(9'b011111111, 9'b011111111, 1'b0, 9'b011111111, 1'b0, 1'b1, 4, 5, 1'b1);

        // Abort an operation while it is normalizing.
        @(negedge clk);
        a = 9'b001110000; b = 9'b001111000; addsub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_s", s, 0);
        check("abort_zero", zero, 0);
        check("abort_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready_next", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | int'(out_valid);
        end
        check("abort_no_output", seen, 0);

        do_op(9'b001010000, 9'b001000000, 1'b0, 9'b001101000, 1'b0, 1'b0, 4, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra  = 9'($urandom);
            rb  = 9'($urandom);
            rop = 1'($urandom);
            model(ra, rb, rop, rs, rz, ro, lat);
            do_op(ra, rb, rop, rs, rz, ro, lat, $urandom_range(0, 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp9_addsub_seq.md
# fp9_addsub_seq

Sequential, handshaked 9-bit floating-point add/subtract responder. It accepts one operand pair plus an operation select over a valid/ready input channel and computes through an align/add/normalize state machine. It returns the packed result with ZERO and OVF flags over a valid/ready output channel. It is the clocked FPU endpoint that our operand sequencers and benches drive in place of the combinational FPU.

## Interface
- GUARD_BITS, 3: extra low-order mantissa bits kept through alignment and normalization; dropped by truncation at pack.
- MAX_ALIGN, 7: cap on alignment shift count; shifts beyond it leave the smaller operand as sticky-only.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- A  in  9  operand A: sign [8], biased exponent [7:5] (bias 3), fraction [4:0]; hidden 1 when exponent != 0; exponent 0 means zero (fraction ignored).
- B  in  9  operand B, same format.
- ADDSUB  in  1  0 = A+B, 1 = A−B.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  block can accept; equals (state == IDLE).
- S  out  9  result, same format; stable while OUT_VALID.
- ZERO  out  1  result is zero.
- OVF  out  1  result saturated on overflow.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE: IN_READY=1. On IN_VALID&IN_READY, register A, B, ADDSUB and go to ALIGN. Later input changes are ignored.
- ALIGN: first cycle unpacks, applies ADDSUB by flipping B's sign, swaps so the larger exponent is in the big operand, and sets d = |Ea−Eb| capped at MAX_ALIGN. Each following cycle shifts the small mantissa right by 1 (sticky OR into LSB) until d shifts are done. If either operand is zero, d is forced to 0 and the zero contributes magnitude 0; result exponent comes from the nonzero operand.
- ADD: one cycle. Signed magnitude add or subtract on (6+GUARD_BITS)-bit mantissas. On subtract, larger magnitude minus smaller; the result sign is taken from the larger magnitude.
- NORM, first cycle:
  - Carry out: right shift 1, exponent+1.
  - Zero magnitude (exact cancellation or both zero): result +0, no shifts.
  - Otherwise: one left shift per extra cycle, exponent−1 each, until the hidden bit is 1 (L shifts).
- Overflow: exponent would exceed 7 → S = {sign,3'b111,5'b11111}, OVF=1.
- Underflow: exponent would drop below 1 → S = 9'b0, ZERO=1.
- Rounding: truncation toward zero of the guard bits.
- DONE: OUT_VALID=1 with S/ZERO/OVF held. On OUT_VALID&OUT_READY, go to IDLE.
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, S=0, ZERO=0, OVF=0.

## Timing
- Pair accepted in cycle N → OUT_VALID first high in cycle N+4+min(d,MAX_ALIGN)+L.
- Handshake: no new accept during a transaction. IN_READY rises in the cycle after the output handshake, never in the same cycle.
- OUT_READY low in DONE holds S/flags indefinitely.
- RST asserted mid-operation: immediate abort to reset values; the captured pair is discarded and the consumer sees no output.
- IN_VALID with IN_READY=0 is ignored; the sender must hold it until accepted.

## Structure
- Package fp9_pkg:
  - Field widths: EXP_W=3, FRAC_W=5, MANT_W=6.
  - EXP_BIAS=3, EXP_MAX=7.
  - State enum fp9_state_t.
  - Field-extract and pack functions.
- Sub-module fp9_pack: combinational final assembly of sign/exponent/mantissa with truncation, overflow saturation, underflow flush and ZERO/OVF generation. Instantiated once.

## Test plan
- A=001010000 (0.75), B=001000000 (0.5), ADDSUB=0 → S=001101000 (1.25), ZERO=0, OVF=0, OUT_VALID at N+4.
- A=000010000, B=000010000, ADDSUB=1 (0−0) → S=000000000, ZERO=1, OUT_VALID at N+4.
- A=001110000 (1.5), B=001111000 (1.75), ADDSUB=1 → S=100100000 (−0.25), L=2, OUT_VALID at N+6.
- A=010111100 (7.5), B=001111000 (1.75), ADDSUB=1 → S=010101110 (5.75), d=2, OUT_VALID at N+6.
- A=011111111, B=011111111, ADDSUB=0 → S=011111111, OVF=1. Hold OUT_READY=0 for 5 cycles: S stable, IN_READY=0, second IN_VALID ignored.
- RST pulsed during NORM of a pending op → all outputs at reset values, IN_READY=1 next cycle, the next transaction completes correctly.
